matrix_scan_ctrl: RTL

Row-scan controller for the 7-row × 5-column LED matrix on the VHDC connector. It holds a double-buffered 7×5 frame and time-multiplexes it onto `rowOut`/`colOut` with a blanking gap between rows. It sits between the clock-rendering/UART-command logic, which writes frames, and the matrix pins. Writers update the back buffer freely. The buffer swap happens only at a frame boundary, so the display never tears.

---
 rtl/matrix_scan_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/matrix_scan_ctrl.sv
// -----------------------------------------------------------------------------
// matrix_scan_ctrl
//
// Row-scan controller for a 7-row x 5-column LED matrix. Two 7x5 frame buffers
// (A and B) are kept. One is displayed (front) and the other is written (back).
// Rows are time-multiplexed onto the pins. Each row gets a blanking gap of
// BLANK_CYCLES, then is driven for DWELL_CYCLES. Front and back are exchanged
// only at a frame boundary, so the display never tears.
//
// Optional feature macro: MATRIX_DIM_EN (adds the bright input and per-row
// PWM dimming of colOut within the dwell window).
//
// Ports
//   CLK          in   1  clock
//   reset        in   1  asynchronous reset, active low
//   wr_en        in   1  write strobe into the back buffer
//   wr_row       in   3  row index 0..6 (7 is ignored)
//   wr_data      in   5  column bits for that row (bit i = column i, 1 = on)
//   swap_req     in   1  pulse: exchange front/back at next frame boundary
//   swap_ack     out  1  pulse on the edge the exchange takes effect
//   swap_pending out  1  request accepted and waiting for the boundary
//   frame_start  out  1  pulse as the row-0 blank phase begins (not the first)
//   rowOut       out  7  one-hot active-high row select
//   colOut       out  5  active-high column drive
//   bright       in   3  (MATRIX_DIM_EN only) intensity, 7 = full
//
// Swap handshake: swap_req is a single-cycle request with no ready. It is
// latched into swap_pending unless one is already pending (requests do not
// queue). At the frame boundary a pending request, or one arriving on that
// very cycle, is serviced: front_sel toggles and swap_ack pulses together
// with frame_start.
// -----------------------------------------------------------------------------
module matrix_scan_ctrl #(
    parameter int DWELL_CYCLES = 12000,
    parameter int BLANK_CYCLES = 200
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_row,
    input  logic [4:0] wr_data,
    input  logic       swap_req,
    output logic       swap_ack,
    output logic       swap_pending,
    output logic       frame_start,
    output logic [6:0] rowOut,
    output logic [4:0] colOut
`ifdef MATRIX_DIM_EN
    ,
    input  logic [2:0] bright
`endif
);

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t        state_q;
    logic [2:0]    row_q;
    logic [CW-1:0] cnt_q;
    logic          front_sel_q;   // 0: A is front, 1: B is front
    logic          pending_q;
    logic [4:0]    buf_a_q [0:6];
    logic [4:0]    buf_b_q [0:6];

    logic [4:0]    front_cols;
    logic [CW-1:0] cnt_d;         // dwell count of the next DRIVE cycle
    logic [4:0]    col_d;         // colOut value for the next DRIVE cycle

`ifdef MATRIX_DIM_EN
    localparam int LW = CW + 4;
    logic [2:0]    bright_q;
    logic [2:0]    bright_sel;
    logic [LW-1:0] lim;
`endif

    assign swap_pending = pending_q;

    // Front-buffer row currently being scanned.
    always_comb begin
        front_cols = 5'd0;
        for (int i = 0; i < 7; i++) begin
            if (row_q == 3'(i)) begin
                front_cols = front_sel_q ? buf_b_q[i] : buf_a_q[i];
            end
        end
    end

    always_comb begin
        cnt_d = (state_q == ST_BLANK) ? '0 : cnt_q + CW'(1);
`ifdef MATRIX_DIM_EN
        // Brightness is taken live on DRIVE entry and held for the rest of the row.
        bright_sel = (state_q == ST_BLANK) ? bright : bright_q;
        lim        = ((LW'(bright_sel) + LW'(1)) * LW'(DWELL_CYCLES)) >> 3;
        col_d      = ({4'd0, cnt_d} < lim) ? front_cols : 5'd0;
`else
        col_d      = front_cols;
`endif
    end

    // Scan FSM with registered outputs.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_BLANK;
            row_q       <= 3'd0;
            cnt_q       <= '0;
            front_sel_q <= 1'b0;
            pending_q   <= 1'b0;
            rowOut      <= 7'd0;
            colOut      <= 5'd0;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
`ifdef MATRIX_DIM_EN
            bright_q    <= 3'd0;
`endif
        end else begin
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
            if (swap_req) begin
                pending_q <= 1'b1;
            end
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_q <= ST_DRIVE;
                        cnt_q   <= '0;
                        rowOut  <= 7'd1 << row_q;
                        colOut  <= col_d;
`ifdef MATRIX_DIM_EN
                        bright_q <= bright;
`endif
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_q <= ST_BLANK;
                        cnt_q   <= '0;
                        rowOut  <= 7'd0;
                        colOut  <= 5'd0;
                        if (row_q == 3'd6) begin
                            // Frame boundary: the only place the buffers may swap.
                            row_q       <= 3'd0;
                            frame_start <= 1'b1;
                            if (pending_q || swap_req) begin
                                front_sel_q <= ~front_sel_q;
                                swap_ack    <= 1'b1;
                                pending_q   <= 1'b0;
                            end
                        end else begin
                            row_q <= row_q + 3'd1;
                        end
                    end else begin
                        cnt_q  <= cnt_d;
                        colOut <= col_d;
                    end
                end
                default: begin
                    state_q <= ST_BLANK;
                end
            endcase
        end
    end

    // Back-buffer writes. front_sel_q is the pre-swap value, so a write on
    // the swap edge lands in the buffer that is about to become the front.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 7; i++) begin
                buf_a_q[i] <= 5'd0;
                buf_b_q[i] <= 5'd0;
            end
        end else if (wr_en && (wr_row != 3'd7)) begin
            if (front_sel_q) begin
                buf_a_q[wr_row] <= wr_data;
            end else begin
                buf_b_q[wr_row] <= wr_data;
            end
        end
    end

endmodule
